// File: rtl/vector_mem_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : vector_mem_sequencer
// Description : Splits one scalar or vector load/store into a burst of N-bit
//               beats on the data-memory port and reassembles read beats.
//               Optional VEC_MEM_STRIDE_EN adds a byte-stride input.
// Revision    : 1.0 - initial release
// =============================================================================
module vector_mem_sequencer #(
    parameter int N      = 32,
    parameter int V      = 256,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             IsVector,
    input  logic             IsWrite,
    input  logic [N-1:0]     Address,
`ifdef VEC_MEM_STRIDE_EN
    input  logic [N-1:0]     Stride,
`endif
    input  logic [N-1:0]     WriteDataS,
    input  logic [V-1:0]     WriteDataV,
    output logic             Busy,
    output logic             Done,
    output logic [N-1:0]     ReadDataS,
    output logic [V-1:0]     ReadDataV,
    output logic [N-1:0]     AddressData,
    output logic [N/8-1:0]   ByteenaData,
    output logic [N-1:0]     WriteData,
    output logic             RdenData,
    output logic             WrenData,
    input  logic [N-1:0]     ReadData
);

    localparam int           BEATS     = V / N;
    localparam int           CW        = $clog2(BEATS + 1);
    localparam logic [N-1:0] ADDR_MASK = ~N'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                is_vec_q, is_vec_d;
    logic [N-1:0]        next_addr_q, next_addr_d;
    logic [V-1:0]        wsh_q, wsh_d;
    logic [CW-1:0]       beat_q, beat_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [V-1:0]        cap_q, cap_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N-1:0]        rd_s_q, rd_s_d;
    logic [V-1:0]        rd_v_q, rd_v_d;
    logic [N-1:0]        addr_q, addr_d;
    logic [N/8-1:0]      be_q, be_d;
    logic [N-1:0]        wdata_q, wdata_d;
    logic                rden_q, rden_d;
    logic                wren_q, wren_d;

    logic [N-1:0]        w_base;
    logic [N-1:0]        w_stride_start;
    logic [N-1:0]        w_stride;
    logic [CW-1:0]       w_nb;

`ifdef VEC_MEM_STRIDE_EN
    logic [N-1:0]        stride_q, stride_d;
    assign w_stride_start = Stride;
    assign w_stride       = stride_q;
`else
    assign w_stride_start = N'(N / 8);
    assign w_stride       = N'(N / 8);
`endif

    assign w_base = Address & ADDR_MASK;
    assign w_nb   = is_vec_q ? CW'(BEATS) : CW'(1);

    always_comb begin
        state_d     = state_q;
        is_vec_d    = is_vec_q;
        next_addr_d = next_addr_q;
        wsh_d       = wsh_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        vld_d       = (vld_q << 1) | RD_LAT'(rden_q);
        rd_s_d      = rd_s_q;
        rd_v_d      = rd_v_q;
        addr_d      = '0;
        be_d        = '0;
        wdata_d     = '0;
        rden_d      = 1'b0;
        wren_d      = 1'b0;
        done_d      = 1'b0;
`ifdef VEC_MEM_STRIDE_EN
        stride_d    = stride_q;
`endif

        // Returning read words land in the capture buffer regardless of state.
        if (vld_q[RD_LAT-1]) begin
            for (int k = 0; k < BEATS; k++) begin
                if (cnt_q == CW'(k)) begin
                    cap_d[k*N +: N] = ReadData;
                end
            end
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    // Beat 0 is issued on the accepting edge so it appears one cycle later.
                    is_vec_d    = IsVector;
                    beat_d      = CW'(1);
                    cnt_d       = '0;
                    addr_d      = w_base;
                    next_addr_d = w_base + w_stride_start;
                    be_d        = '1;
                    wsh_d       = WriteDataV >> N;
`ifdef VEC_MEM_STRIDE_EN
                    stride_d    = Stride;
`endif
                    if (IsWrite) begin
                        state_d = S_WRITE;
                        wren_d  = 1'b1;
                        wdata_d = IsVector ? WriteDataV[N-1:0] : WriteDataS;
                    end else begin
                        state_d = S_READ;
                        rden_d  = 1'b1;
                    end
                end
            end
            S_WRITE, S_READ: begin
                if (beat_q == w_nb) begin
                    state_d = (state_q == S_WRITE) ? S_IDLE : S_DRAIN;
                    done_d  = (state_q == S_WRITE);
                end else begin
                    addr_d      = next_addr_q & ADDR_MASK;
                    next_addr_d = next_addr_q + w_stride;
                    be_d        = '1;
                    beat_d      = beat_q + 1'b1;
                    if (state_q == S_WRITE) begin
                        wren_d  = 1'b1;
                        wdata_d = wsh_q[N-1:0];
                        wsh_d   = wsh_q >> N;
                    end else begin
                        rden_d  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_d == w_nb) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (is_vec_q) begin
                        rd_v_d = cap_d;
                    end else begin
                        rd_s_d = cap_d[N-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            is_vec_q    <= 1'b0;
            next_addr_q <= '0;
            wsh_q       <= '0;
            beat_q      <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            vld_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_s_q      <= '0;
            rd_v_q      <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
`ifdef VEC_MEM_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            is_vec_q    <= is_vec_d;
            next_addr_q <= next_addr_d;
            wsh_q       <= wsh_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            vld_q       <= vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_s_q      <= rd_s_d;
            rd_v_q      <= rd_v_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
`ifdef VEC_MEM_STRIDE_EN
            stride_q    <= stride_d;
`endif
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign ReadDataS   = rd_s_q;
    assign ReadDataV   = rd_v_q;
    assign AddressData = addr_q;
    assign ByteenaData = be_q;
    assign WriteData   = wdata_q;
    assign RdenData    = rden_q;
    assign WrenData    = wren_q;

endmodule
`default_nettype wire
